// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// State enum, access-width codes and the unsigned flag bit position.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSP_IF = 2'd1,
        RSP_LS = 2'd2
    } state_t;

    localparam logic [2:0] W_BYTE = 3'b000;
    localparam logic [2:0] W_HALF = 3'b001;
    localparam logic [2:0] W_WORD = 3'b010;

    localparam int W_UNSIGNED_BIT = 2;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Counts consecutive cycles in which fetch asks but is refused.
// at_max tells the arbiter that fetch must win the next contention.
module mem_arb_starve_cnt #(
    parameter int MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic req,
    input  logic gnt,
    output logic at_max
);

    logic [3:0] cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= 4'd0;
        end else if (!req || gnt) begin
            cnt <= 4'd0;
        end else if (cnt != 4'(MAX)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign at_max = (cnt == 4'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port.
// Handshake: a request is accepted in the cycle its gnt is high; its rvalid pulses the next cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [2:0]    ls_width,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [31:0]   ls_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [2:0]    mem_width,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output state_t        dbg_state
);

    state_t state, state_nxt;
    logic   fetch_first;
    logic [31:0] if_rdata_q, ls_rdata_q;

    mem_arb_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .req     (if_req),
        .gnt     (if_gnt),
        .at_max  (fetch_first)
    );

    // Grants are masked by reset so nothing is accepted before the first live edge.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (i_rst_n) begin
            if (if_req && (!ls_req || fetch_first)) begin
                if_gnt = 1'b1;
            end else if (ls_req) begin
                ls_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_addr  = if_addr;
        mem_width = W_WORD;
        mem_we    = 1'b0;
        mem_wdata = 32'd0;
        if (ls_gnt) begin
            mem_addr  = ls_addr;
            mem_width = ls_width;
            mem_we    = ls_we;
            mem_wdata = ls_wdata;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (if_gnt) begin
            state_nxt = RSP_IF;
        end else if (ls_gnt) begin
            state_nxt = RSP_LS;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response words are captured at the granting edge and held until the next grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            if_rdata_q <= 32'd0;
            ls_rdata_q <= 32'd0;
        end else begin
            if (if_gnt) begin
                if_rdata_q <= mem_rdata;
            end
            if (ls_gnt) begin
                ls_rdata_q <= ls_we ? 32'd0 : mem_rdata;
            end
        end
    end

    assign if_rvalid = (state == RSP_IF);
    assign ls_rvalid = (state == RSP_LS);
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed checks of mem_arbiter against a transaction-level model.
// The bench also plays the byte-addressed memory behind the shared port.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int STARVE_MAX = 4;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          ls_req = 1'b0, ls_we = 1'b0;
    logic [2:0]    ls_width = 3'b000;
    logic [AW-1:0] ls_addr = '0;
    logic [31:0]   ls_wdata = '0;
    logic          ls_gnt, ls_rvalid;
    logic [31:0]   ls_rdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_width;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    state_t        dbg_state;

    mem_arbiter #(.AW(AW), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_width(ls_width),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
        .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_addr(mem_addr), .mem_width(mem_width), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- memory environment ----------------
    logic [7:0] env_mem [256];
    logic [7:0] ref_mem [256];

    function automatic logic [31:0] load_val(logic [31:0] raw, logic [2:0] w);
        if (w[1]) return raw;
        if (w[0]) return w[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        return w[2] ? {24'd0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
    endfunction

    always_comb begin
        logic [7:0] a;
        a = mem_addr[7:0];
        mem_rdata = load_val({env_mem[8'(a + 8'd3)], env_mem[8'(a + 8'd2)],
                              env_mem[8'(a + 8'd1)], env_mem[a]}, mem_width);
    end

    always @(posedge i_clk) begin
        if (mem_we) begin
            env_mem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_width[1] || mem_width[0])
                env_mem[8'(mem_addr[7:0] + 8'd1)] <= mem_wdata[15:8];
            if (mem_width[1]) begin
                env_mem[8'(mem_addr[7:0] + 8'd2)] <= mem_wdata[23:16];
                env_mem[8'(mem_addr[7:0] + 8'd3)] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] if_exp_q[$];
    logic [31:0] ls_exp_q[$];
    logic [31:0] last_if = 32'd0, last_ls = 32'd0;
    int starve = 0;
    int gnt_cnt = 0, rsp_cnt = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(logic [7:0] a, logic [2:0] w);
        return load_val({ref_mem[8'(a + 8'd3)], ref_mem[8'(a + 8'd2)],
                         ref_mem[8'(a + 8'd1)], ref_mem[a]}, w);
    endfunction

    task automatic ref_store(logic [7:0] a, logic [2:0] w, logic [31:0] d);
        int nbytes;
        nbytes = w[1] ? 4 : (w[0] ? 2 : 1);
        for (int i = 0; i < nbytes; i++) ref_mem[8'(a + 8'(i))] = d[8*i +: 8];
    endtask

    // One cycle: check last edge's responses, drive, check combinational port, advance model.
    task automatic step(input logic ir, input logic [AW-1:0] ia, input logic lr,
                        input logic lwe, input logic [2:0] lw,
                        input logic [AW-1:0] la, input logic [31:0] ld);
        logic e_if, e_ls;
        @(negedge i_clk);
        check("if_rvalid", if_rvalid, if_exp_q.size() > 0);
        if (if_exp_q.size() > 0) begin
            last_if = if_exp_q.pop_front();
            rsp_cnt++;
        end
        check("if_rdata", if_rdata, last_if);
        check("ls_rvalid", ls_rvalid, ls_exp_q.size() > 0);
        if (ls_exp_q.size() > 0) begin
            last_ls = ls_exp_q.pop_front();
            rsp_cnt++;
        end
        check("ls_rdata", ls_rdata, last_ls);

        if_req = ir; if_addr = ia; ls_req = lr; ls_we = lwe;
        ls_width = lw; ls_addr = la; ls_wdata = ld;
        #1;
        e_if = ir && (!lr || starve == STARVE_MAX);
        e_ls = lr && !e_if;
        check("if_gnt", if_gnt, e_if);
        check("ls_gnt", ls_gnt, e_ls);
        check("mem_addr", mem_addr, e_ls ? la : ia);
        check("mem_width", mem_width, e_ls ? lw : W_WORD);
        check("mem_we", mem_we, e_ls && lwe);
        if (e_ls && lwe) check("mem_wdata", mem_wdata, ld);

        if (e_if) begin
            if_exp_q.push_back(ref_read(ia[7:0], W_WORD));
            gnt_cnt++;
        end
        if (e_ls) begin
            gnt_cnt++;
            if (lwe) begin
                ls_exp_q.push_back(32'd0);
                ref_store(la[7:0], lw, ld);
            end else begin
                ls_exp_q.push_back(ref_read(la[7:0], lw));
            end
        end
        if (!ir || e_if) starve = 0;
        else if (starve < STARVE_MAX) starve++;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 3'b000, '0, '0);
    endtask

    task automatic model_reset();
        if_exp_q.delete();
        ls_exp_q.delete();
        last_if = 32'd0;
        last_ls = 32'd0;
        starve = 0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_if_gnt"}, if_gnt, 1'b0);
        check({tag, "_ls_gnt"}, ls_gnt, 1'b0);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_if_rvalid"}, if_rvalid, 1'b0);
        check({tag, "_ls_rvalid"}, ls_rvalid, 1'b0);
        check({tag, "_if_rdata"}, if_rdata, 32'd0);
        check({tag, "_ls_rdata"}, ls_rdata, 32'd0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] width_tbl [5];

    initial begin
        logic [AW-1:0] a;
        logic [2:0] w;
        width_tbl[0] = 3'b000; width_tbl[1] = 3'b001; width_tbl[2] = 3'b010;
        width_tbl[3] = 3'b100; width_tbl[4] = 3'b101;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        {env_mem[19], env_mem[18], env_mem[17], env_mem[16]} = 32'h00A00093;
        {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]} = 32'h00A00093;

        // Reset with both requesters asking, including a store.
        if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b1;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("rst");
        i_rst_n = 1'b1;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;

        // Fetch only.
        step(1'b1, 32'h10, 1'b0, 1'b0, 3'b000, '0, '0);
        check("f_if_gnt", if_gnt, 1'b1);
        idle();
        check("f_if_rvalid", if_rvalid, 1'b1);
        check("f_if_rdata", if_rdata, 32'h00A00093);
        check("f_ls_rvalid", ls_rvalid, 1'b0);

        // Contention: ls for STARVE_MAX cycles, then fetch.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'(4 * i), 1'b1, 1'b0, 3'b010, 32'(64 + 4 * i), '0);
            check("c_if_gnt", if_gnt, (i == 4 || i == 9));
            check("c_ls_gnt", ls_gnt, !(i == 4 || i == 9));
        end
        idle();

        // Store byte then signed and unsigned byte loads.
        step(1'b0, '0, 1'b1, 1'b1, W_BYTE, 32'h20, 32'h1FF);
        step(1'b0, '0, 1'b1, 1'b0, W_BYTE, 32'h20, '0);
        check("s_ack", ls_rvalid, 1'b1);
        check("s_ack_data", ls_rdata, 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 3'b100, 32'h20, '0);
        check("l_signed", ls_rdata, 32'hFFFFFFFF);
        idle();
        check("l_unsigned", ls_rdata, 32'h000000FF);

        // Reset mid-read, requests left high while in reset.
        step(1'b0, '0, 1'b1, 1'b0, W_WORD, 32'h10, '0);
        #1 i_rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("mid");
        @(negedge i_clk);
        check_reset_outputs("mid2");
        i_rst_n = 1'b1;
        ls_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 32'h10, 1'b1, 1'b0, W_WORD, 32'h20, '0);
            check("r_if_gnt", if_gnt, i == 4);
        end
        idle();

        // Back-to-back alternating single requesters.
        idle();
        gnt_cnt = 0;
        rsp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1'b1, 32'(4 * i), 1'b0, 1'b0, 3'b000, '0, '0);
            else step(1'b0, '0, 1'b1, 1'b0, W_WORD, 32'(128 + 4 * i), '0);
        end
        idle();
        check("b2b_gnts", gnt_cnt, 8);
        check("b2b_rsps", rsp_cnt, 8);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            w = width_tbl[$urandom_range(0, 4)];
            a = 32'($urandom_range(0, 255));
            if (w[1]) a[1:0] = 2'b00;
            else if (w[0]) a[0] = 1'b0;
            step($urandom_range(0, 3) != 0, {$urandom, 2'b00} & 32'hFC,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, w, a, $urandom);
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning requester and memory address width in bits.
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive denied fetch cycles before fetch takes priority (legal range 1..15).
REQ-003 i_clk  input  1  clock; all state updates occur on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch read request.
REQ-006 if_addr  input  AW  fetch word address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid, if_rdata  output  1, 32  fetch response strobe and word.
REQ-009 ls_req, ls_we  input  1, 1  load/store request and write enable.
REQ-010 ls_width  input  3  access width code: bit0 = half, bit1 = word, neither = byte, bit2 = unsigned.
REQ-011 ls_addr, ls_wdata  input  AW, 32  load/store address and store data.
REQ-012 ls_gnt  output  1  load/store request accepted this cycle.
REQ-013 ls_rvalid, ls_rdata  output  1, 32  load/store response strobe and data.
REQ-014 mem_addr, mem_width, mem_we, mem_wdata  output  AW, 3, 1, 32  shared memory port; writes are synchronous, reads combinational.
REQ-015 mem_rdata  input  32  combinational read data from the shared memory.

Function
REQ-016 SHALL grant at most one requester per cycle; a grant is combinational, in the same cycle as the request.
REQ-017 SHALL grant the sole requester when only one of if_req or ls_req is high.
REQ-018 SHALL resolve contention (both requests high) in favour of ls, unless the starvation count equals STARVE_MAX, in which case fetch wins.
REQ-019 Starvation count SHALL increment when if_req=1 and if_gnt=0, saturating at STARVE_MAX.
REQ-020 Starvation count SHALL clear to 0 when if_gnt=1 or if_req=0.
REQ-021 On a fetch grant, mem_addr SHALL equal if_addr, mem_width SHALL be 3'b010 and mem_we SHALL be 0.
REQ-022 On an ls grant, mem_addr, mem_width, mem_wdata and mem_we SHALL equal ls_addr, ls_width, ls_wdata and ls_we.
REQ-023 With no grant, mem_we SHALL be 0, mem_addr SHALL equal if_addr and mem_width SHALL be 3'b010.
REQ-024 The FSM SHALL have states IDLE, RSP_IF and RSP_LS, with the next state being RSP_IF on a fetch grant, RSP_LS on an ls grant, and IDLE otherwise.
REQ-025 The FSM SHALL evaluate its next state every cycle, with no stall state.
REQ-026 On a granted read, mem_rdata SHALL be registered at the granting edge.
REQ-027 After a granted read, the owner's rvalid SHALL pulse exactly one cycle after grant, with rdata equal to the registered value.
REQ-028 On a granted store, ls_rvalid SHALL pulse one cycle after grant as an acknowledge, with ls_rdata = 0.
REQ-029 if_rdata and ls_rdata SHALL hold their last value while the corresponding rvalid is 0.
REQ-030 Back-to-back grants to either requester SHALL be accepted every cycle, giving full throughput.
REQ-031 A grant SHALL never depend on an outstanding response, so a response and a new grant may coincide.

Reset
REQ-032 While i_rst_n=0: state = IDLE, starvation count = 0, if_rvalid = ls_rvalid = 0, if_rdata = ls_rdata = 0, if_gnt = ls_gnt = 0, mem_we = 0.
REQ-033 Reset asserted mid-access SHALL drop any pending response with no rvalid pulse.
REQ-034 Reset asserted in the same cycle as a store grant SHALL suppress mem_we.
REQ-035 The first grant after reset release SHALL occur no earlier than the first rising edge with i_rst_n=1.

Structure
REQ-036 A shared package mem_arb_pkg SHALL hold the FSM state enum (IDLE, RSP_IF, RSP_LS).
REQ-037 mem_arb_pkg SHALL hold the width-code constants W_BYTE = 3'b000, W_HALF = 3'b001, W_WORD = 3'b010 and the unsigned bit index 2.
REQ-038 The starvation counter SHALL be one sub-module, mem_arb_starve_cnt, with inputs req and gnt, parameter MAX, and output at_max.

Verification
REQ-039 Fetch only: if_req=1, if_addr=0x10, memory word 0x10 = 0x00A00093 -> if_gnt=1 the same cycle; if_rvalid=1 with if_rdata=0x00A00093 next cycle; ls outputs quiet.
REQ-040 Contention: both requests held high with STARVE_MAX=4 -> ls granted 4 cycles, fetch granted cycle 5, ls cycles 6-9, fetch cycle 10.
REQ-041 Store then load: ls store, width 3'b000, addr 0x20, wdata 0x1FF -> ls_rvalid ack with rdata 0; next load, width 3'b000 -> ls_rdata 0xFFFFFFFF; width 3'b100 -> 0x000000FF.
REQ-042 Reset mid-read: grant a load, then drive i_rst_n=0 before the next edge -> no ls_rvalid pulse; all outputs 0; the count is 0 after release.
REQ-043 Back-to-back: alternate fetch-only and ls-only requests for 8 cycles -> 8 grants and 8 rvalid pulses, each one cycle late, on the correct port with no loss.
